voice_allocator: RTL and testbench

Polyphonic note scheduler sitting between the keyboard/MIDI front end and a bank of `NUM_VOICES` square-wave generator instances. It accepts note-on/note-off events over a valid/ready handshake and assigns each note to a generator voice by driving that voice's frequency and amplitude inputs. A frequency of 0 silences a generator, so freeing a voice means writing 0. The mixer downstream sums the generator outputs.

---
 rtl/voice_allocator.sv | 202 ++++++++++++++++++++
 tb/tb_voice_allocator.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// voice_allocator: assigns note-on/note-off events to NUM_VOICES square-wave generators.
// Build macro VOICE_STEAL_EN: when every voice is busy, steal the oldest voice instead of dropping the note.
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int FREQ_W     = 16,
    parameter int AMP_W      = 6,
    parameter int AGE_W      = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         note_valid,
    output logic                         note_ready,
    input  logic                         note_on,
    input  logic [FREQ_W-1:0]            note_freq,
    input  logic [AMP_W-1:0]             note_amp,
    output logic [NUM_VOICES*FREQ_W-1:0] voice_freq,
    output logic [NUM_VOICES*AMP_W-1:0]  voice_amp,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic                         stolen,
    output logic                         dropped
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t                 state;
    logic                   cap_on;
    logic [FREQ_W-1:0]      cap_freq;
    logic [AMP_W-1:0]       cap_amp;
    logic [IDX_W-1:0]       scan_idx;
    logic                   match_found;
    logic                   free_found;
    logic [IDX_W-1:0]       match_idx;
    logic [IDX_W-1:0]       free_idx;
    logic [FREQ_W-1:0]      freq_q [NUM_VOICES];
    logic [AMP_W-1:0]       amp_q  [NUM_VOICES];
    logic [NUM_VOICES-1:0]  active_q;
    logic                   evt_q;

    logic                   load_en;
    logic                   clear_en;
    logic                   evt_c;
    logic [IDX_W-1:0]       tgt_idx;

`ifdef VOICE_STEAL_EN
    logic [AGE_W-1:0]       age_q [NUM_VOICES];
    logic                   oldest_found;
    logic [IDX_W-1:0]       oldest_idx;
    logic [AGE_W-1:0]       oldest_age;

    function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
        return (a == {AGE_W{1'b1}}) ? a : a + AGE_W'(1);
    endfunction

    assign stolen  = evt_q;
    assign dropped = 1'b0;
`else
    assign stolen  = 1'b0;
    assign dropped = evt_q;
`endif

    // Decision applied on the COMMIT edge; evt_c marks a note-on that found no match and no free voice.
    always_comb begin
        load_en  = 1'b0;
        clear_en = 1'b0;
        evt_c    = 1'b0;
        tgt_idx  = match_idx;
        if (cap_on) begin
            if (cap_freq != '0) begin
                if (match_found) begin
                    load_en = 1'b1;
                end else if (free_found) begin
                    load_en = 1'b1;
                    tgt_idx = free_idx;
                end else begin
                    evt_c = 1'b1;
`ifdef VOICE_STEAL_EN
                    load_en = 1'b1;
                    tgt_idx = oldest_idx;
`endif
                end
            end
        end else if (match_found) begin
            clear_en = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            note_ready  <= 1'b1;
            cap_on      <= 1'b0;
            cap_freq    <= '0;
            cap_amp     <= '0;
            scan_idx    <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            active_q    <= '0;
            evt_q       <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                freq_q[v] <= '0;
                amp_q[v]  <= '0;
`ifdef VOICE_STEAL_EN
                age_q[v]  <= '0;
`endif
            end
`ifdef VOICE_STEAL_EN
            oldest_found <= 1'b0;
            oldest_idx   <= '0;
            oldest_age   <= '0;
`endif
        end else begin
            evt_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (note_valid) begin
                        cap_on      <= note_on;
                        cap_freq    <= note_freq;
                        cap_amp     <= note_amp;
                        scan_idx    <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
`ifdef VOICE_STEAL_EN
                        oldest_found <= 1'b0;
`endif
                        note_ready  <= 1'b0;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (active_q[scan_idx] && freq_q[scan_idx] == cap_freq && !match_found) begin
                        match_found <= 1'b1;
                        match_idx   <= scan_idx;
                    end
                    if (!active_q[scan_idx] && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_idx;
                    end
`ifdef VOICE_STEAL_EN
                    // Strict compare keeps the lowest index on equal ages.
                    if (active_q[scan_idx] && (!oldest_found || age_q[scan_idx] > oldest_age)) begin
                        oldest_found <= 1'b1;
                        oldest_idx   <= scan_idx;
                        oldest_age   <= age_q[scan_idx];
                    end
`endif
                    if (scan_idx == IDX_W'(NUM_VOICES - 1)) begin
                        state <= COMMIT;
                    end else begin
                        scan_idx <= scan_idx + IDX_W'(1);
                    end
                end
                COMMIT: begin
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (load_en && tgt_idx == IDX_W'(v)) begin
                            freq_q[v]   <= cap_freq;
                            amp_q[v]    <= cap_amp;
                            active_q[v] <= 1'b1;
`ifdef VOICE_STEAL_EN
                            age_q[v]    <= '0;
`endif
                        end else if (clear_en && tgt_idx == IDX_W'(v)) begin
                            freq_q[v]   <= '0;
                            amp_q[v]    <= '0;
                            active_q[v] <= 1'b0;
`ifdef VOICE_STEAL_EN
                            age_q[v]    <= '0;
`endif
                        end
`ifdef VOICE_STEAL_EN
                        else if (load_en && active_q[v]) begin
                            age_q[v] <= age_sat_inc(age_q[v]);
                        end
`endif
                    end
                    evt_q      <= evt_c;
                    note_ready <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    note_ready <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        voice_freq = '0;
        voice_amp  = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            voice_freq[v*FREQ_W +: FREQ_W] = freq_q[v];
            voice_amp[v*AMP_W +: AMP_W]    = amp_q[v];
        end
    end

    assign voice_active = active_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: a behavioural voice model pushes expected outputs per event.
module tb_voice_allocator;

    localparam int NV  = 4;
    localparam int FW  = 16;
    localparam int AW  = 6;
    localparam int AGW = 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             note_valid = 1'b0;
    logic             note_ready;
    logic             note_on = 1'b0;
    logic [FW-1:0]    note_freq = '0;
    logic [AW-1:0]    note_amp = '0;
    logic [NV*FW-1:0] voice_freq;
    logic [NV*AW-1:0] voice_amp;
    logic [NV-1:0]    voice_active;
    logic             stolen;
    logic             dropped;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [NV*FW-1:0] f;
        logic [NV*AW-1:0] a;
        logic [NV-1:0]    act;
        logic             st;
        logic             dr;
    } exp_t;

    exp_t sb[$];

    logic [FW-1:0] m_freq [NV];
    logic [AW-1:0] m_amp  [NV];
    logic          m_act  [NV];
    int            m_age  [NV];

    voice_allocator #(.NUM_VOICES(NV), .FREQ_W(FW), .AMP_W(AW), .AGE_W(AGW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .note_valid   (note_valid),
        .note_ready   (note_ready),
        .note_on      (note_on),
        .note_freq    (note_freq),
        .note_amp     (note_amp),
        .voice_freq   (voice_freq),
        .voice_amp    (voice_amp),
        .voice_active (voice_active),
        .stolen       (stolen),
        .dropped      (dropped)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NV; i++) begin
            m_freq[i] = '0;
            m_amp[i]  = '0;
            m_act[i]  = 1'b0;
            m_age[i]  = 0;
        end
    endtask

    task automatic model_event(input logic on, input logic [FW-1:0] f, input logic [AW-1:0] a);
        exp_t e;
        int   mi, fi, oi, tgt;
        logic ev;
        mi = -1; fi = -1; oi = -1; tgt = -1; ev = 1'b0;
        for (int i = 0; i < NV; i++) begin
            if (m_act[i] && m_freq[i] == f && mi < 0) mi = i;
            if (!m_act[i] && fi < 0) fi = i;
            if (m_act[i] && (oi < 0 || m_age[i] > m_age[oi])) oi = i;
        end
        if (on) begin
            if (f != 0) begin
                if (mi >= 0) tgt = mi;
                else if (fi >= 0) tgt = fi;
                else begin
                    ev = 1'b1;
`ifdef VOICE_STEAL_EN
                    tgt = oi;
`endif
                end
                if (tgt >= 0) begin
                    for (int i = 0; i < NV; i++)
                        if (i != tgt && m_act[i] && m_age[i] < (1 << AGW) - 1) m_age[i]++;
                    m_freq[tgt] = f;
                    m_amp[tgt]  = a;
                    m_act[tgt]  = 1'b1;
                    m_age[tgt]  = 0;
                end
            end
        end else if (mi >= 0) begin
            m_freq[mi] = '0;
            m_amp[mi]  = '0;
            m_act[mi]  = 1'b0;
            m_age[mi]  = 0;
        end
        e.f = '0; e.a = '0; e.act = '0;
        for (int i = 0; i < NV; i++) begin
            e.f[i*FW +: FW] = m_freq[i];
            e.a[i*AW +: AW] = m_amp[i];
            e.act[i]        = m_act[i];
        end
`ifdef VOICE_STEAL_EN
        e.st = ev; e.dr = 1'b0;
`else
        e.st = 1'b0; e.dr = ev;
`endif
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_clear();
        @(negedge clk);
    endtask

    task automatic send_event(input logic on, input logic [FW-1:0] f, input logic [AW-1:0] a);
        exp_t e;
        int   lat;
        @(negedge clk);
        note_valid = 1'b1;
        note_on    = on;
        note_freq  = f;
        note_amp   = a;
        model_event(on, f, a);
        @(posedge clk);
        #1;
        note_valid = 1'b0;
        note_on    = 1'($urandom);
        note_freq  = FW'($urandom);
        note_amp   = AW'($urandom);
        lat = 0;
        while (!note_ready && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, NV + 1);
        e = sb.pop_front();
        chk("voice_freq", voice_freq, e.f);
        chk("voice_amp", voice_amp, e.a);
        chk("voice_active", voice_active, e.act);
        chk("stolen", stolen, e.st);
        chk("dropped", dropped, e.dr);
        @(posedge clk);
        #1;
        chk("pulse_clear", {stolen, dropped}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        do_reset();
        chk("rst_freq", voice_freq, 0);
        chk("rst_amp", voice_amp, 0);
        chk("rst_active", voice_active, 0);
        chk("rst_ready", note_ready, 1);
        chk("rst_pulses", {stolen, dropped}, 0);

        send_event(1'b1, 16'd440, 6'd20);
        chk("first_v0_freq", voice_freq[15:0], 440);
        chk("first_v0_amp", voice_amp[5:0], 20);
        chk("first_active", voice_active, 4'b0001);

        send_event(1'b1, 16'd550, 6'd21);
        send_event(1'b1, 16'd660, 6'd22);
        send_event(1'b0, 16'd550, 6'd0);
        chk("off_v1_freq", voice_freq[31:16], 0);
        chk("off_active", voice_active, 4'b0101);
        send_event(1'b1, 16'd880, 6'd23);
        chk("reuse_v1_freq", voice_freq[31:16], 880);

        do_reset();
        send_event(1'b1, 16'd440, 6'd20);
        send_event(1'b1, 16'd550, 6'd21);
        send_event(1'b1, 16'd660, 6'd22);
        send_event(1'b1, 16'd770, 6'd23);
        chk("full_active", voice_active, 4'b1111);
        send_event(1'b1, 16'd440, 6'd10);
        chk("retrig_v0_amp", voice_amp[5:0], 10);
        chk("retrig_v0_freq", voice_freq[15:0], 440);
        send_event(1'b1, 16'd990, 6'd30);
`ifdef VOICE_STEAL_EN
        chk("steal_v1_freq", voice_freq[31:16], 990);
        chk("steal_v1_amp", voice_amp[11:6], 30);
`else
        chk("drop_v1_freq", voice_freq[31:16], 550);
        chk("drop_v1_amp", voice_amp[11:6], 21);
`endif
        send_event(1'b0, 16'd123, 6'd5);
        send_event(1'b1, 16'd0, 6'd5);

        for (int n = 0; n < 40; n++) begin
            logic [FW-1:0] f;
            f = FW'(100 * $urandom_range(0, 6));
            send_event($urandom_range(0, 2) != 0, f, AW'($urandom));
        end

        do_reset();
        send_event(1'b1, 16'd440, 6'd9);
        send_event(1'b1, 16'd550, 6'd11);
        chk("pre_abort_active", voice_active, 4'b0011);
        @(negedge clk);
        note_valid = 1'b1;
        note_on    = 1'b1;
        note_freq  = 16'd660;
        note_amp   = 6'd7;
        @(posedge clk);
        #1;
        note_valid = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_freq", voice_freq, 0);
        chk("abort_amp", voice_amp, 0);
        chk("abort_active", voice_active, 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_clear();
        repeat (8) @(posedge clk);
        #1;
        chk("abort_after_freq", voice_freq, 0);
        chk("abort_after_active", voice_active, 0);
        chk("abort_after_ready", note_ready, 1);
        chk("abort_after_pulses", {stolen, dropped}, 0);
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
